evg_event_arbiter: RTL and testbench
====================================

// Module: evg_event_arbiter
// PURPOSE
//  Shares the single event-code slot of the EVG transmit stream among N_REQ requesters
//  (sequencer, software event, external triggers, heartbeat).
//  Latches one pending code per requester and rejects null/TOD codes.
//  Grants at most one code per free slot (strict-priority requesters first, round-robin
//  among the rest) and counts per-requester overruns.
//  Sits in the evgTxClk domain ahead of the TX character mux that feeds evgTxData/evgTxCharIsK.
// PARAMETERS
//  N_REQ          4        number of requesters (2..8)
//  PRIORITY_MASK  4'b0001  bit i=1: requester i is strict-priority (lowest index wins among these)
//  CNT_WIDTH      16       width of each saturating overrun counter
// PORTS
//  evgTxClk       in   1              event stream clock; sole clock
//  evgTxRst_n     in   1              reset, asynchronous assert, active-low
//  enable         in   1              0: no grants issued; requests still latched
//  clearCounts    in   1              1-cycle pulse: zero all overrun counters
//  reqStrobe      in   N_REQ          1-cycle request pulse per requester
//  reqCode        in   8*N_REQ        event code, requester i at [8i+7:8i], valid with reqStrobe[i]
//  slotAvail      in   1              1: the next TX cycle may carry an event code
//  evCode         out  8              granted event code; 8'h00 when evCodeValid=0
//  evCodeValid    out  1              1-cycle pulse per granted code
//  evCodeSrc      out  3              index of requester granted, valid with evCodeValid
//  pendingMask    out  N_REQ          bit i=1: requester i holds an ungranted code
//  rejectStrobe   out  N_REQ          1-cycle pulse: reqCode was 0x00, 0x70 or 0x71 and was discarded
//  overrunCount   out  CNT_WIDTH*N_REQ  per-requester saturating overrun count
// BEHAVIOUR
//  Reset: all outputs 0, pending/code regs 0, round-robin pointer 0.
//  Request cycle T (reqStrobe[i]=1):
//  - Reserved code: not latched; rejectStrobe[i]=1 at T+1; no counter change.
//  - Not pending: latch code; pendingMask[i]=1 at T+1.
//  - Pending, not granted at T: new code discarded, old one kept; overrunCount[i]++ (saturate at all-ones).
//  - Pending and granted at T: new code latched; pending stays 1; no overrun.
//  Grant cycle G: requires enable=1, slotAvail=1, pendingMask!=0.
//  - Winner: lowest-index pending bit within PRIORITY_MASK.
//  - Otherwise: first pending non-priority requester at or after rrPtr, with wrap-around.
//  - rrPtr moves to winner+1 (mod N_REQ) only on non-priority grants.
//  - At G+1: evCode=code, evCodeValid=1, evCodeSrc=winner; pending[winner] clears unless re-latched at G.
//  Latency: strobe at T, earliest evCodeValid at T+2. Never more than one grant per cycle.
//  slotAvail=0 or enable=0: no grant, pending state retained; deasserting enable never flushes.
//  clearCounts and overrun in the same cycle: clear wins (counter=0).
//  All requesters pending with slotAvail held 1: every non-priority requester is granted
//  within N_REQ consecutive non-priority grants (no starvation among non-priority).
//  Asynchronous reset mid-operation: pending codes lost, no partial evCodeValid; first grant
//  no earlier than 2 cycles after evgTxRst_n deasserts.
// STRUCTURE
//  Package evg_arb_pkg:
//  - EV_CODE_NULL=8'h00, EV_CODE_TOD0=8'h70, EV_CODE_TOD1=8'h71
//  - function isReservedCode(code)
//  - typedef evCode_t (8-bit)
//  Sub-module evg_rr_arbiter (N, PRIORITY_MASK):
//  - in: request mask, pointer; out: one-hot grant, grant index, any
//  - combinational, reused by the sequencer mux.
//  Top module holds pending/code registers, counters and output registers.
// TESTING
//  1. Req1 code 0x2A at T, slotAvail=1, enable=1 -> evCodeValid at T+2, evCode=0x2A, evCodeSrc=1;
//     pendingMask[1]=0 at T+3.
//  2. Req2 codes 0x00, 0x70, 0x71 -> rejectStrobe[2] pulses x3, never evCodeValid,
//     overrunCount[2]=0.
//  3. slotAvail=0; req3 0x10 then 0x11 -> pending code 0x10, overrunCount[3]=1.
//     slotAvail=1 -> evCode=0x10 only.
//  4. Requesters 0..3 strobe 0x01..0x04 together, PRIORITY_MASK=0001, slotAvail=1
//     -> grant order 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
//     Repeat: rrPtr continues from requester 1.
//  5. 2^CNT_WIDTH+3 overruns on req0 -> overrunCount[0]=all-ones.
//     clearCounts same cycle as an overrun -> 0.
//  6. evgTxRst_n asserted low while 3 requesters pending -> outputs 0 immediately,
//     pendingMask=0; no evCodeValid after release until a new strobe.

Source files
------------

// File: rtl/evg_arb_pkg.sv
// Shared constants, types and helpers for the EVG event-code arbiter.
package evg_arb_pkg;

  localparam logic [7:0] EV_CODE_NULL = 8'h00;
  localparam logic [7:0] EV_CODE_TOD0 = 8'h70;
  localparam logic [7:0] EV_CODE_TOD1 = 8'h71;

  // Requester index width; fixed at 3 bits so evCodeSrc covers up to 8 requesters.
  localparam int IDX_W = 3;

  typedef logic [7:0] evCode_t;

  // Null and time-of-day codes are owned by other parts of the stream and never arbitrated.
  function automatic logic isReservedCode(input evCode_t code);
    return (code == EV_CODE_NULL) || (code == EV_CODE_TOD0) || (code == EV_CODE_TOD1);
  endfunction

endpackage

// File: rtl/evg_rr_arbiter.sv
// Combinational strict-priority + round-robin arbiter for up to 8 requesters.
module evg_rr_arbiter
  import evg_arb_pkg::*;
#(
  parameter int           N             = 4,
  parameter logic [N-1:0] PRIORITY_MASK = '0
) (
  input  logic [N-1:0]     reqMask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grantOneHot,
  output logic [IDX_W-1:0] grantIdx,
  output logic             grantAny
);

  logic [N-1:0] prioReq;
  logic [N-1:0] rrReq;

  assign prioReq = reqMask & PRIORITY_MASK;
  assign rrReq   = reqMask & ~PRIORITY_MASK;

  function automatic int wrapIdx(input logic [IDX_W-1:0] base, input int k);
    return (int'(base) + k) % N;
  endfunction

  // Priority requesters win by lowest index; otherwise first non-priority request at/after ptr.
  always_comb begin
    grantOneHot = '0;
    grantIdx    = '0;
    grantAny    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (prioReq[i] && !grantAny) begin
        grantAny       = 1'b1;
        grantIdx       = IDX_W'(i);
        grantOneHot[i] = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!grantAny && rrReq[wrapIdx(ptr, k)]) begin
        grantAny                     = 1'b1;
        grantIdx                     = IDX_W'(wrapIdx(ptr, k));
        grantOneHot[wrapIdx(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/evg_event_arbiter.sv
// Shares the EVG event-code slot among requesters: holds one pending code per
// requester, drops reserved codes, grants one code per free slot, counts overruns.
module evg_event_arbiter
  import evg_arb_pkg::*;
#(
  parameter int                 N_REQ         = 4,
  parameter logic [N_REQ-1:0]   PRIORITY_MASK = 4'b0001,
  parameter int                 CNT_WIDTH     = 16
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxRst_n,
  input  logic                       enable,
  input  logic                       clearCounts,
  input  logic [N_REQ-1:0]           reqStrobe,
  input  logic [8*N_REQ-1:0]         reqCode,
  input  logic                       slotAvail,
  output logic [7:0]                 evCode,
  output logic                       evCodeValid,
  output logic [IDX_W-1:0]           evCodeSrc,
  output logic [N_REQ-1:0]           pendingMask,
  output logic [N_REQ-1:0]           rejectStrobe,
  output logic [CNT_WIDTH*N_REQ-1:0] overrunCount
);

  evCode_t                codeReg [N_REQ];
  logic [CNT_WIDTH-1:0]   cntReg  [N_REQ];
  logic [IDX_W-1:0]       rrPtr;
  logic [IDX_W-1:0]       rrNext;
  logic [IDX_W:0]         ptrInc;

  logic [N_REQ-1:0]       grantOneHot;
  logic [IDX_W-1:0]       grantIdx;
  logic                   grantAny;
  logic                   grantFire;
  logic                   grantIsPrio;
  logic [N_REQ-1:0]       grantHit;
  evCode_t                grantCode;

  logic [N_REQ-1:0]       reqReserved;
  logic [N_REQ-1:0]       reqLatch;
  logic [N_REQ-1:0]       reqOverrun;

  evg_rr_arbiter #(
    .N             (N_REQ),
    .PRIORITY_MASK (PRIORITY_MASK)
  ) u_rrArbiter (
    .reqMask     (pendingMask),
    .ptr         (rrPtr),
    .grantOneHot (grantOneHot),
    .grantIdx    (grantIdx),
    .grantAny    (grantAny)
  );

  assign grantFire   = enable & slotAvail & grantAny;
  assign grantHit    = grantOneHot & {N_REQ{grantFire}};
  assign grantIsPrio = |(grantOneHot & PRIORITY_MASK);
  assign ptrInc      = {1'b0, grantIdx} + 1'b1;
  assign rrNext      = (ptrInc >= (IDX_W+1)'(N_REQ)) ? '0 : ptrInc[IDX_W-1:0];

  // Classify each request and select the granted code; a granted slot may re-latch in the same cycle.
  always_comb begin
    reqReserved = '0;
    reqLatch    = '0;
    reqOverrun  = '0;
    grantCode   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (reqStrobe[i]) begin
        if (isReservedCode(reqCode[8*i +: 8])) begin
          reqReserved[i] = 1'b1;
        end else if (!pendingMask[i] || grantHit[i]) begin
          reqLatch[i] = 1'b1;
        end else begin
          reqOverrun[i] = 1'b1;
        end
      end
      grantCode = grantCode | (codeReg[i] & {8{grantHit[i]}});
    end
  end

  // Pending flags and held codes.
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      pendingMask <= '0;
      for (int i = 0; i < N_REQ; i++) codeReg[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (reqLatch[i]) begin
          pendingMask[i] <= 1'b1;
          codeReg[i]     <= reqCode[8*i +: 8];
        end else if (grantHit[i]) begin
          pendingMask[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating overrun counters; a clear pulse overrides a coincident overrun.
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      for (int i = 0; i < N_REQ; i++) cntReg[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (clearCounts) begin
          cntReg[i] <= '0;
        end else if (reqOverrun[i] && (cntReg[i] != '1)) begin
          cntReg[i] <= cntReg[i] + 1'b1;
        end
      end
    end
  end

  // Registered grant/reject outputs; round-robin pointer only advances on non-priority grants.
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      evCode       <= '0;
      evCodeValid  <= 1'b0;
      evCodeSrc    <= '0;
      rejectStrobe <= '0;
      rrPtr        <= '0;
    end else begin
      evCodeValid  <= grantFire;
      evCode       <= grantFire ? grantCode : '0;
      evCodeSrc    <= grantFire ? grantIdx : '0;
      rejectStrobe <= reqReserved;
      if (grantFire && !grantIsPrio) rrPtr <= rrNext;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cntOut
    assign overrunCount[CNT_WIDTH*g +: CNT_WIDTH] = cntReg[g];
  end

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Bench for evg_event_arbiter: directed scenarios plus random traffic, every cycle
// compared against a queue/array reference model of the arbitration rules.
module tb_evg_event_arbiter;

  localparam int N  = 4;
  localparam int CW = 16;

  logic            evgTxClk = 1'b0;
  logic            evgTxRst_n = 1'b0;
  logic            enable = 1'b0;
  logic            clearCounts = 1'b0;
  logic [N-1:0]    reqStrobe = '0;
  logic [8*N-1:0]  reqCode = '0;
  logic            slotAvail = 1'b0;
  logic [7:0]      evCode;
  logic            evCodeValid;
  logic [2:0]      evCodeSrc;
  logic [N-1:0]    pendingMask;
  logic [N-1:0]    rejectStrobe;
  logic [CW*N-1:0] overrunCount;

  evg_event_arbiter #(.N_REQ(N), .PRIORITY_MASK(4'b0001), .CNT_WIDTH(CW)) dut (
    .evgTxClk     (evgTxClk),
    .evgTxRst_n   (evgTxRst_n),
    .enable       (enable),
    .clearCounts  (clearCounts),
    .reqStrobe    (reqStrobe),
    .reqCode      (reqCode),
    .slotAvail    (slotAvail),
    .evCode       (evCode),
    .evCodeValid  (evCodeValid),
    .evCodeSrc    (evCodeSrc),
    .pendingMask  (pendingMask),
    .rejectStrobe (rejectStrobe),
    .overrunCount (overrunCount)
  );

  always #5 evgTxClk = ~evgTxClk;

  int total = 0;
  int bad   = 0;

  bit         prio  [N] = '{1'b1, 1'b0, 1'b0, 1'b0};
  bit         mPend [N];
  logic [7:0] mCode [N];
  int         mCnt  [N];
  int         mRr;
  bit         eValid;
  logic [7:0] eCode;
  int         eSrc;
  logic [N-1:0] eRej;
  logic [7:0] grantLog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reservedCode(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'h70) || (c == 8'h71);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mPend[i] = 1'b0;
      mCode[i] = 8'h00;
      mCnt[i]  = 0;
    end
    mRr    = 0;
    eValid = 1'b0;
    eCode  = 8'h00;
    eSrc   = 0;
    eRej   = '0;
  endtask

  task automatic checkAll(input string tag);
    logic [N-1:0] pm;
    for (int i = 0; i < N; i++) pm[i] = mPend[i];
    chk({tag, ".valid"}, 32'(evCodeValid), 32'(eValid));
    chk({tag, ".code"}, 32'(evCode), 32'(eCode));
    chk({tag, ".src"}, 32'(evCodeSrc), eSrc);
    chk({tag, ".pending"}, 32'(pendingMask), 32'(pm));
    chk({tag, ".reject"}, 32'(rejectStrobe), 32'(eRej));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s.cnt%0d", tag, i), 32'(overrunCount[CW*i +: CW]), mCnt[i]);
  endtask

  // Advance one clock with the currently driven inputs, predicting the registered results.
  task automatic cycle(input string tag);
    int         w;
    bit         oldPend [N];
    logic [7:0] c;
    w = -1;
    oldPend = mPend;
    if (enable && slotAvail) begin
      for (int i = 0; i < N; i++)
        if (w < 0 && prio[i] && mPend[i]) w = i;
      for (int k = 0; k < N; k++)
        if (w < 0 && !prio[(mRr + k) % N] && mPend[(mRr + k) % N]) w = (mRr + k) % N;
    end
    eValid = (w >= 0);
    eCode  = (w >= 0) ? mCode[w] : 8'h00;
    eSrc   = (w >= 0) ? w : 0;
    if (w >= 0) begin
      mPend[w] = 1'b0;
      if (!prio[w]) mRr = (w + 1) % N;
    end
    eRej = '0;
    for (int i = 0; i < N; i++) begin
      if (reqStrobe[i]) begin
        c = reqCode[8*i +: 8];
        if (reservedCode(c)) eRej[i] = 1'b1;
        else if (!oldPend[i] || w == i) begin
          mPend[i] = 1'b1;
          mCode[i] = c;
        end else if (mCnt[i] < (2**CW) - 1) mCnt[i]++;
      end
    end
    if (clearCounts)
      for (int i = 0; i < N; i++) mCnt[i] = 0;
    @(posedge evgTxClk);
    #1;
    if (evCodeValid) grantLog.push_back(evCode);
    checkAll(tag);
    reqStrobe   = '0;
    clearCounts = 1'b0;
  endtask

  task automatic strobe(input int idx, input logic [7:0] code);
    reqStrobe[idx]       = 1'b1;
    reqCode[8*idx +: 8]  = code;
  endtask

  logic [7:0] resCodes [3] = '{8'h00, 8'h70, 8'h71};
  logic [7:0] exp4     [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    modelReset();
    #12;
    checkAll("reset");
    @(posedge evgTxClk);
    #1;
    evgTxRst_n = 1'b1;
    enable     = 1'b1;
    slotAvail  = 1'b1;

    // single request, grant two cycles after the strobe
    strobe(1, 8'h2A);
    cycle("t1_req");
    cycle("t1_grant");
    cycle("t1_after");

    // reserved codes are rejected without touching counters
    for (int k = 0; k < 3; k++) begin
      strobe(2, resCodes[k]);
      cycle("t2_rej");
    end
    cycle("t2_idle");

    // overrun while the slot is blocked keeps the first code
    grantLog.delete();
    slotAvail = 1'b0;
    strobe(3, 8'h10);
    cycle("t3_first");
    strobe(3, 8'h11);
    cycle("t3_overrun");
    cycle("t3_hold");
    slotAvail = 1'b1;
    for (int k = 0; k < 3; k++) cycle("t3_drain");
    chk("t3_logsize", grantLog.size(), 1);
    if (grantLog.size() > 0) chk("t3_logcode", 32'(grantLog[0]), 32'h10);

    // all four together, twice: priority first then round-robin order
    grantLog.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) strobe(i, 8'(i + 1));
      for (int k = 0; k < 5; k++) cycle("t4_round");
    end
    chk("t4_logsize", grantLog.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < grantLog.size()) chk($sformatf("t4_order%0d", k), 32'(grantLog[k]), 32'(exp4[k]));

    // counter saturation, then clear beats a coincident overrun
    slotAvail = 1'b0;
    for (int k = 0; k < (2**CW) + 4; k++) begin
      strobe(0, 8'h55);
      cycle("t5_sat");
    end
    chk("t5_saturated", 32'(overrunCount[CW-1:0]), 32'hFFFF);
    strobe(0, 8'h56);
    clearCounts = 1'b1;
    cycle("t5_clear");
    chk("t5_cleared", 32'(overrunCount[CW-1:0]), 32'h0);
    slotAvail = 1'b1;
    for (int k = 0; k < 3; k++) cycle("t5_drain");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      enable      = ($urandom_range(0, 7) != 0);
      slotAvail   = ($urandom_range(0, 2) != 0);
      clearCounts = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) strobe(i, resCodes[$urandom_range(0, 2)]);
          else strobe(i, 8'($urandom));
        end
      end
      cycle("rand");
    end

    // asynchronous reset with several requesters pending
    enable    = 1'b1;
    slotAvail = 1'b0;
    strobe(1, 8'h21);
    strobe(2, 8'h22);
    strobe(3, 8'h23);
    cycle("t6_load");
    #2;
    evgTxRst_n = 1'b0;
    modelReset();
    #1;
    checkAll("t6_inreset");
    @(posedge evgTxClk);
    #1;
    checkAll("t6_held");
    evgTxRst_n = 1'b1;
    slotAvail  = 1'b1;
    for (int k = 0; k < 4; k++) cycle("t6_idle");
    strobe(2, 8'h33);
    cycle("t6_req");
    cycle("t6_grant");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
